// File: rtl/pgm_pkg.sv
// Shared definitions for the packet generator: header tags, FSM states and
// the default beat width of the 134-bit data path.
package pgm_pkg;

  localparam int DEFAULT_DATA_W = 134;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } pgm_state_t;

endpackage

// File: rtl/pgm_tpl_ram.sv
// Template store: simple dual-port RAM, synchronous write, registered read
// with one cycle of latency. Contents are not cleared by reset.
module pgm_tpl_ram
  import pgm_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one template beat per strobe.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: data appears the cycle after the read is issued.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pgm_gen.sv
// Packet generator: passes traffic through while idle, captures one template
// packet into RAM, and replays it as a counted or continuous burst with a
// programmable gap between packets.
module pgm_gen
  import pgm_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH),
  parameter int CNT_W  = 32,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_pgm_data,
  input  logic              in_pgm_data_wr,
  input  logic              in_pgm_valid,
  input  logic              in_pgm_valid_wr,
  output logic              out_pgm_alf,
  output logic [DATA_W-1:0] out_pgm_data,
  output logic              out_pgm_data_wr,
  output logic              out_pgm_valid,
  output logic              out_pgm_valid_wr,
  input  logic              in_pgm_alf,
  input  logic              cfg_capture_en,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_continuous,
  input  logic [CNT_W-1:0]  cfg_pkt_count,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic              out_pgm_sent_start_flag,
  output logic              out_pgm_sent_finish_flag,
  output logic              stat_tpl_valid,
  output logic [AW:0]       stat_tpl_len,
  output logic [CNT_W-1:0]  stat_sent_cnt,
  output logic              stat_cap_err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  pgm_state_t state_q, state_d;

  logic [1:0]        in_tag;
  logic              in_tail, in_open, head_beat;
  logic              mid_pkt_q, fwd_pkt_q;
  logic [DATA_W-1:0] pt_data_q;
  logic              pt_wr_q, pt_valid_q, pt_valid_wr_q;

  logic [AW:0]       cap_cnt_q, tpl_len_q;
  logic              cap_drop_q, tpl_valid_q, cap_err_q;

  logic [AW-1:0]     rd_addr_q;
  logic [GAP_W-1:0]  gap_cnt_q, gap_q;
  logic [CNT_W-1:0]  cnt_q, sent_cnt_q, sent_inc, sent_ref;
  logic              cont_q, stop_pend_q, stop_now, last_addr, burst_end;
  logic              rd_vld_q, rd_last_q, start_flag_q, finish_flag_q;
  logic [DATA_W-1:0] ram_rd_data;

  logic              fwd, cap_wr, tpl_done, cap_ovf;
  logic              burst_go, rd_en, pkt_done, finish;
  logic [AW-1:0]     cap_addr;

  assign in_tag    = in_pgm_data[DATA_W-1 -: 2];
  assign in_tail   = (in_tag == TAG_TAIL);
  assign in_open   = (in_tag == TAG_HEAD) || (in_tag == TAG_MID);
  assign head_beat = in_pgm_data_wr && !mid_pkt_q;

  assign last_addr = ({1'b0, rd_addr_q} == tpl_len_q - 1'b1);
  assign sent_inc  = (&sent_cnt_q) ? sent_cnt_q : sent_cnt_q + 1'b1;
  assign sent_ref  = (state_q == SEND) ? sent_inc : sent_cnt_q;
  assign stop_now  = stop_pend_q || cfg_stop;
  assign burst_end = stop_now || (!cont_q && (sent_ref == cnt_q));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    fwd      = 1'b0;
    cap_wr   = 1'b0;
    cap_addr = '0;
    tpl_done = 1'b0;
    cap_ovf  = 1'b0;
    burst_go = 1'b0;
    rd_en    = 1'b0;
    pkt_done = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        fwd = !(mid_pkt_q && !fwd_pkt_q);
        if (cfg_capture_en && head_beat) begin
          fwd    = 1'b0;
          cap_wr = 1'b1;
          if (in_tail) tpl_done = 1'b1;
          else         state_d  = CAP;
        end else if (cfg_start && tpl_valid_q &&
                     (cfg_continuous || (cfg_pkt_count != '0))) begin
          burst_go = 1'b1;
          state_d  = SEND;
        end
      end
      CAP: begin
        if (in_pgm_data_wr) begin
          if (cap_drop_q) begin
            if (in_tail) state_d = IDLE;
          end else if (cap_cnt_q == DEPTH_L) begin
            cap_ovf = 1'b1;
            if (in_tail) state_d = IDLE;
          end else begin
            cap_wr   = 1'b1;
            cap_addr = cap_cnt_q[AW-1:0];
            if (in_tail) begin
              tpl_done = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      SEND: begin
        if (!in_pgm_alf) begin
          rd_en = 1'b1;
          if (last_addr) begin
            pkt_done = 1'b1;
            if (gap_q != '0) begin
              state_d = GAP;
            end else if (burst_end) begin
              finish  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == gap_q - 1'b1) begin
          if (burst_end) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Input packet tracking and the one-cycle pass-through register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mid_pkt_q     <= 1'b0;
      fwd_pkt_q     <= 1'b0;
      pt_data_q     <= '0;
      pt_wr_q       <= 1'b0;
      pt_valid_q    <= 1'b0;
      pt_valid_wr_q <= 1'b0;
    end else begin
      if (in_pgm_data_wr) mid_pkt_q <= in_open;
      if (state_q != IDLE)                fwd_pkt_q <= 1'b0;
      else if (fwd && in_pgm_data_wr)     fwd_pkt_q <= in_open;
      pt_data_q     <= fwd ? in_pgm_data : '0;
      pt_wr_q       <= fwd && in_pgm_data_wr;
      pt_valid_q    <= fwd && in_pgm_valid;
      pt_valid_wr_q <= fwd && in_pgm_valid_wr;
    end
  end

  // Template capture bookkeeping: write pointer, length, validity, overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_cnt_q   <= '0;
      tpl_len_q   <= '0;
      tpl_valid_q <= 1'b0;
      cap_drop_q  <= 1'b0;
      cap_err_q   <= 1'b0;
    end else begin
      if (cap_wr) cap_cnt_q <= {1'b0, cap_addr} + 1'b1;
      if (tpl_done) begin
        tpl_len_q   <= {1'b0, cap_addr} + 1'b1;
        tpl_valid_q <= 1'b1;
      end else if (cap_ovf) begin
        tpl_len_q   <= '0;
        tpl_valid_q <= 1'b0;
      end else if (state_q == IDLE && cap_wr) begin
        tpl_valid_q <= 1'b0;
      end
      cap_drop_q <= (state_d == CAP) && (cap_drop_q || cap_ovf);
      cap_err_q  <= cap_ovf;
    end
  end

  // Burst control: latched settings, stop request, counters and read address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      gap_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      sent_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      if (burst_go) begin
        cnt_q       <= cfg_pkt_count;
        gap_q       <= cfg_gap;
        cont_q      <= cfg_continuous;
        stop_pend_q <= 1'b0;
        sent_cnt_q  <= '0;
        rd_addr_q   <= '0;
      end else begin
        if ((state_q == SEND || state_q == GAP) && cfg_stop) stop_pend_q <= 1'b1;
        if (pkt_done) sent_cnt_q <= sent_inc;
        if (rd_en) rd_addr_q <= last_addr ? '0 : rd_addr_q + 1'b1;
      end
      gap_cnt_q <= (state_q == GAP && state_d == GAP) ? gap_cnt_q + 1'b1 : '0;
    end
  end

  // Replay pipeline stage aligned with the RAM latency, plus burst flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      start_flag_q  <= 1'b0;
      finish_flag_q <= 1'b0;
    end else begin
      rd_vld_q      <= rd_en;
      rd_last_q     <= pkt_done;
      start_flag_q  <= burst_go;
      finish_flag_q <= finish;
    end
  end

  pgm_tpl_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_tpl_ram (
    .clk     (clk),
    .wr_en   (cap_wr),
    .wr_addr (cap_addr),
    .wr_data (in_pgm_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_data (ram_rd_data)
  );

  assign out_pgm_alf              = (state_q == IDLE) ? in_pgm_alf : (state_q != CAP);
  assign out_pgm_data             = rd_vld_q ? ram_rd_data : pt_data_q;
  assign out_pgm_data_wr          = rd_vld_q || pt_wr_q;
  assign out_pgm_valid            = (rd_vld_q && rd_last_q) || pt_valid_q;
  assign out_pgm_valid_wr         = (rd_vld_q && rd_last_q) || pt_valid_wr_q;
  assign out_pgm_sent_start_flag  = start_flag_q;
  assign out_pgm_sent_finish_flag = finish_flag_q;
  assign stat_tpl_valid           = tpl_valid_q;
  assign stat_tpl_len             = tpl_len_q;
  assign stat_sent_cnt            = sent_cnt_q;
  assign stat_cap_err             = cap_err_q;

endmodule

// File: tb/tb_pgm_gen.sv
// Directed testbench for pgm_gen with an 8-beat template store.
module tb_pgm_gen;
  import pgm_pkg::*;

  localparam int DW = 134;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int CW = 32;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_pgm_data;
  logic          in_pgm_data_wr, in_pgm_valid, in_pgm_valid_wr, in_pgm_alf;
  logic          out_pgm_alf;
  logic [DW-1:0] out_pgm_data;
  logic          out_pgm_data_wr, out_pgm_valid, out_pgm_valid_wr;
  logic          cfg_capture_en, cfg_start, cfg_stop, cfg_continuous;
  logic [CW-1:0] cfg_pkt_count;
  logic [GW-1:0] cfg_gap;
  logic          out_pgm_sent_start_flag, out_pgm_sent_finish_flag;
  logic          stat_tpl_valid, stat_cap_err;
  logic [AW:0]   stat_tpl_len;
  logic [CW-1:0] stat_sent_cnt;

  pgm_gen #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_pgm_data(in_pgm_data), .in_pgm_data_wr(in_pgm_data_wr),
    .in_pgm_valid(in_pgm_valid), .in_pgm_valid_wr(in_pgm_valid_wr),
    .out_pgm_alf(out_pgm_alf),
    .out_pgm_data(out_pgm_data), .out_pgm_data_wr(out_pgm_data_wr),
    .out_pgm_valid(out_pgm_valid), .out_pgm_valid_wr(out_pgm_valid_wr),
    .in_pgm_alf(in_pgm_alf),
    .cfg_capture_en(cfg_capture_en), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous), .cfg_pkt_count(cfg_pkt_count), .cfg_gap(cfg_gap),
    .out_pgm_sent_start_flag(out_pgm_sent_start_flag),
    .out_pgm_sent_finish_flag(out_pgm_sent_finish_flag),
    .stat_tpl_valid(stat_tpl_valid), .stat_tpl_len(stat_tpl_len),
    .stat_sent_cnt(stat_sent_cnt), .stat_cap_err(stat_cap_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs every beat with its cycle and counts flag pulses.
  logic [DW-1:0] out_q[$];
  int            beat_cyc[$];
  int            vwr_cnt = 0, start_cnt = 0, finish_cnt = 0, cerr_cnt = 0;
  always @(negedge clk) begin
    if (out_pgm_data_wr) begin
      out_q.push_back(out_pgm_data);
      beat_cyc.push_back(cyc);
    end
    if (out_pgm_valid_wr)         vwr_cnt++;
    if (out_pgm_sent_start_flag)  start_cnt++;
    if (out_pgm_sent_finish_flag) finish_cnt++;
    if (stat_cap_err)             cerr_cnt++;
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] tpl[4];

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkBeat(input logic [1:0] tag, input int id);
    return {tag, 100'h5A5A, 32'(id)};
  endfunction

  function automatic logic [DW-1:0] beatAt(input int i);
    if (i < out_q.size()) return out_q[i];
    return '0;
  endfunction

  function automatic int cycAt(input int i);
    if (i < beat_cyc.size()) return beat_cyc[i];
    return -1000;
  endfunction

  task automatic applyStimulus(input logic [DW-1:0] beat, input logic vld);
    in_pgm_data     = beat;
    in_pgm_data_wr  = 1'b1;
    in_pgm_valid    = vld;
    in_pgm_valid_wr = vld;
    @(posedge clk); #1;
    in_pgm_data_wr  = 1'b0;
    in_pgm_valid    = 1'b0;
    in_pgm_valid_wr = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic waitFinish(input int f0, input int limit);
    int n = 0;
    while (finish_cnt == f0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (finish_cnt == f0) checkOutput("finish timeout", DW'(0), DW'(1));
  endtask

  int b, v0, s0, f0, e0, dc;

  initial begin
    tpl[0] = mkBeat(TAG_HEAD, 1);
    tpl[1] = mkBeat(TAG_MID, 2);
    tpl[2] = mkBeat(TAG_MID, 3);
    tpl[3] = mkBeat(TAG_TAIL, 4);
    rst_n = 1'b0;
    in_pgm_data = '0; in_pgm_data_wr = 0; in_pgm_valid = 0; in_pgm_valid_wr = 0;
    in_pgm_alf = 0; cfg_capture_en = 0; cfg_start = 0; cfg_stop = 0;
    cfg_continuous = 0; cfg_pkt_count = '0; cfg_gap = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst data_wr", DW'(out_pgm_data_wr), DW'(0));
    checkOutput("rst valid_wr", DW'(out_pgm_valid_wr), DW'(0));
    checkOutput("rst tpl_valid", DW'(stat_tpl_valid), DW'(0));
    checkOutput("rst sent_cnt", DW'(stat_sent_cnt), DW'(0));
    checkOutput("rst alf", DW'(out_pgm_alf), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitCycles(1);

    // Pass-through
    $display("[TB] pass-through");
    b = out_q.size(); v0 = vwr_cnt; dc = cyc;
    applyStimulus(mkBeat(TAG_HEAD, 11), 1'b0);
    applyStimulus(mkBeat(TAG_MID, 12), 1'b0);
    applyStimulus(mkBeat(TAG_TAIL, 13), 1'b1);
    waitCycles(3);
    checkOutput("pt count", DW'(out_q.size() - b), DW'(3));
    checkOutput("pt beat0", beatAt(b), mkBeat(TAG_HEAD, 11));
    checkOutput("pt beat1", beatAt(b + 1), mkBeat(TAG_MID, 12));
    checkOutput("pt beat2", beatAt(b + 2), mkBeat(TAG_TAIL, 13));
    checkOutput("pt latency", DW'(cycAt(b) - dc), DW'(1));
    checkOutput("pt valid_wr", DW'(vwr_cnt - v0), DW'(1));
    in_pgm_alf = 1'b1; #1;
    checkOutput("pt alf hi", DW'(out_pgm_alf), DW'(1));
    in_pgm_alf = 1'b0; #1;
    checkOutput("pt alf lo", DW'(out_pgm_alf), DW'(0));

    // Capture a 4-beat template
    $display("[TB] capture");
    b = out_q.size();
    cfg_capture_en = 1'b1;
    applyStimulus(tpl[0], 1'b0);
    in_pgm_alf = 1'b1; #1;
    checkOutput("cap alf", DW'(out_pgm_alf), DW'(0));
    applyStimulus(tpl[1], 1'b0);
    applyStimulus(tpl[2], 1'b0);
    applyStimulus(tpl[3], 1'b1);
    in_pgm_alf = 1'b0; cfg_capture_en = 1'b0;
    waitCycles(2);
    checkOutput("cap len", DW'(stat_tpl_len), DW'(4));
    checkOutput("cap valid", DW'(stat_tpl_valid), DW'(1));
    checkOutput("cap no output", DW'(out_q.size() - b), DW'(0));

    // Burst: 3 packets, gap 5
    $display("[TB] burst count=3 gap=5");
    b = out_q.size(); v0 = vwr_cnt; s0 = start_cnt; f0 = finish_cnt;
    cfg_pkt_count = 3; cfg_gap = 5; cfg_continuous = 1'b0;
    pulseStart();
    checkOutput("send alf", DW'(out_pgm_alf), DW'(1));
    waitFinish(f0, 300);
    waitCycles(3);
    checkOutput("burst count", DW'(out_q.size() - b), DW'(12));
    for (int i = 0; i < 12; i++) checkOutput("burst beat", beatAt(b + i), tpl[i % 4]);
    checkOutput("burst gap1", DW'(cycAt(b + 4) - cycAt(b + 3) - 1), DW'(5));
    checkOutput("burst gap2", DW'(cycAt(b + 8) - cycAt(b + 7) - 1), DW'(5));
    checkOutput("burst back2back", DW'(cycAt(b + 3) - cycAt(b)), DW'(3));
    checkOutput("burst valid_wr", DW'(vwr_cnt - v0), DW'(3));
    checkOutput("burst start", DW'(start_cnt - s0), DW'(1));
    checkOutput("burst finish", DW'(finish_cnt - f0), DW'(1));
    checkOutput("burst sent", DW'(stat_sent_cnt), DW'(3));

    // Backpressure toggling every 3 cycles
    $display("[TB] backpressure");
    b = out_q.size(); f0 = finish_cnt;
    cfg_pkt_count = 2; cfg_gap = 0;
    pulseStart();
    fork
      begin
        for (int n = 0; n < 60 && finish_cnt == f0; n++) begin
          @(posedge clk); #1;
          if (n % 3 == 2) in_pgm_alf = ~in_pgm_alf;
        end
      end
      waitFinish(f0, 300);
    join
    in_pgm_alf = 1'b0;
    waitCycles(3);
    checkOutput("bp count", DW'(out_q.size() - b), DW'(8));
    for (int i = 0; i < 8; i++) checkOutput("bp beat", beatAt(b + i), tpl[i % 4]);
    checkOutput("bp sent", DW'(stat_sent_cnt), DW'(2));

    // Continuous with stop during packet 7
    $display("[TB] continuous + stop");
    b = out_q.size(); v0 = vwr_cnt; f0 = finish_cnt;
    cfg_continuous = 1'b1; cfg_pkt_count = 0; cfg_gap = 2;
    pulseStart();
    for (int n = 0; n < 400 && (out_q.size() - b) < 26; n++) @(negedge clk);
    cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_stop = 1'b0;
    waitFinish(f0, 300);
    waitCycles(3);
    checkOutput("stop sent", DW'(stat_sent_cnt), DW'(7));
    checkOutput("stop count", DW'(out_q.size() - b), DW'(28));
    checkOutput("stop valid_wr", DW'(vwr_cnt - v0), DW'(7));
    checkOutput("stop last beat", beatAt(b + 27), tpl[3]);
    checkOutput("stop finish", DW'(finish_cnt - f0), DW'(1));
    cfg_continuous = 1'b0;

    // Overflow: 10-beat packet into 8-beat store
    $display("[TB] overflow");
    b = out_q.size(); e0 = cerr_cnt; s0 = start_cnt;
    cfg_capture_en = 1'b1;
    applyStimulus(mkBeat(TAG_HEAD, 21), 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(mkBeat(TAG_MID, 22 + i), 1'b0);
    applyStimulus(mkBeat(TAG_TAIL, 30), 1'b1);
    cfg_capture_en = 1'b0;
    waitCycles(2);
    checkOutput("ovf err pulse", DW'(cerr_cnt - e0), DW'(1));
    checkOutput("ovf tpl_valid", DW'(stat_tpl_valid), DW'(0));
    cfg_pkt_count = 1; cfg_gap = 0;
    pulseStart();
    waitCycles(8);
    checkOutput("ovf no output", DW'(out_q.size() - b), DW'(0));
    checkOutput("ovf start ignored", DW'(start_cnt - s0), DW'(0));

    // Single-beat template
    $display("[TB] length-1 template");
    b = out_q.size(); s0 = start_cnt;
    cfg_capture_en = 1'b1;
    applyStimulus(mkBeat(TAG_TAIL, 40), 1'b1);
    cfg_capture_en = 1'b0;
    waitCycles(1);
    checkOutput("len1 len", DW'(stat_tpl_len), DW'(1));
    checkOutput("len1 valid", DW'(stat_tpl_valid), DW'(1));
    cfg_pkt_count = 0;
    pulseStart();
    waitCycles(3);
    checkOutput("zero count ignored", DW'(start_cnt - s0), DW'(0));
    checkOutput("len1 no output", DW'(out_q.size() - b), DW'(0));
    v0 = vwr_cnt; f0 = finish_cnt;
    cfg_pkt_count = 2; cfg_gap = 1;
    pulseStart();
    waitFinish(f0, 100);
    waitCycles(3);
    checkOutput("len1 count", DW'(out_q.size() - b), DW'(2));
    checkOutput("len1 beat0", beatAt(b), mkBeat(TAG_TAIL, 40));
    checkOutput("len1 beat1", beatAt(b + 1), mkBeat(TAG_TAIL, 40));
    checkOutput("len1 valid_wr", DW'(vwr_cnt - v0), DW'(2));
    checkOutput("len1 gap", DW'(cycAt(b + 1) - cycAt(b)), DW'(2));

    // Reset in the middle of a continuous burst
    $display("[TB] reset mid-send");
    b = out_q.size();
    cfg_continuous = 1'b1; cfg_gap = 0;
    pulseStart();
    for (int n = 0; n < 50 && (out_q.size() - b) < 3; n++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_continuous = 1'b0;
    @(negedge clk);
    checkOutput("mrst data_wr", DW'(out_pgm_data_wr), DW'(0));
    checkOutput("mrst data", out_pgm_data, DW'(0));
    checkOutput("mrst valid_wr", DW'(out_pgm_valid_wr), DW'(0));
    checkOutput("mrst alf", DW'(out_pgm_alf), DW'(0));
    checkOutput("mrst tpl_valid", DW'(stat_tpl_valid), DW'(0));
    checkOutput("mrst sent", DW'(stat_sent_cnt), DW'(0));
    @(posedge clk); #1;
    b = out_q.size(); v0 = vwr_cnt;
    applyStimulus(mkBeat(TAG_TAIL, 50), 1'b1);
    waitCycles(3);
    checkOutput("mrst pt count", DW'(out_q.size() - b), DW'(1));
    checkOutput("mrst pt beat", beatAt(b), mkBeat(TAG_TAIL, 50));
    checkOutput("mrst pt valid_wr", DW'(vwr_cnt - v0), DW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pgm_gen.md
Name: pgm_gen

Overview:
- Parametrised successor of the pipeline packet generator.
- Captures one template packet from the data stream into internal RAM, then replays it as a programmable burst with a programmable inter-packet gap.
- Adds single-burst and continuous modes, stop-after-current-packet, overflow detection and a sent-packet counter.
- Sits between GAC and GOE on the 134-bit data path. Passes traffic through unchanged while idle.

Parameters:
- DATA_W, 134: beat width; bits [DATA_W-1:DATA_W-2] are the header tag (01 head, 11 middle, 10 tail).
- DEPTH, 128: template capacity in beats; must be a power of two.
- AW, $clog2(DEPTH): template address width.
- CNT_W, 32: width of the burst count and the sent counter.
- GAP_W, 16: width of the inter-packet gap in cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_pgm_data  in  DATA_W  input beat
- in_pgm_data_wr  in  1  input beat strobe
- in_pgm_valid  in  1  packet valid flag
- in_pgm_valid_wr  in  1  packet valid strobe; accompanies the tail beat
- out_pgm_alf  out  1  almost-full to upstream
- out_pgm_data  out  DATA_W  output beat
- out_pgm_data_wr  out  1  output beat strobe
- out_pgm_valid  out  1  output packet valid flag
- out_pgm_valid_wr  out  1  output packet valid strobe
- in_pgm_alf  in  1  downstream almost-full
- cfg_capture_en  in  1  level; capture the next whole packet as the template
- cfg_start  in  1  pulse; begin the burst
- cfg_stop  in  1  pulse; end after the current packet
- cfg_continuous  in  1  1 = repeat until stop; 0 = send cfg_pkt_count packets
- cfg_pkt_count  in  CNT_W  packets per burst
- cfg_gap  in  GAP_W  idle cycles between packets
- out_pgm_sent_start_flag  out  1  one-cycle pulse at burst start
- out_pgm_sent_finish_flag  out  1  one-cycle pulse at burst end
- stat_tpl_valid  out  1  a template is held
- stat_tpl_len  out  AW+1  template length in beats
- stat_sent_cnt  out  CNT_W  packets sent in the current burst
- stat_cap_err  out  1  one-cycle pulse on template overflow

Behaviour:
- Reset: all outputs 0; state IDLE; tpl_valid=0; counters 0. The RAM contents need not be cleared.
- State IDLE:
  - Input is registered to output with 1-cycle latency; out_pgm_alf = in_pgm_alf.
  - If cfg_capture_en=1 and a head beat arrives: write it at address 0, do not forward it, go to CAP.
  - If cfg_start=1, tpl_valid=1 and (cfg_continuous or cfg_pkt_count≠0): latch count, gap and mode; clear stat_sent_cnt; pulse start_flag; go to SEND.
  - If cfg_start=1 under any other condition: ignore it.
  - Capture takes priority over start when both occur in the same cycle.
- State CAP:
  - Each beat is written at the incrementing address; out_pgm_alf=0; nothing is output.
  - On the tail beat: tpl_len = beats written, tpl_valid=1, return to IDLE.
  - Beat DEPTH+1 without a tail: tpl_valid=0, pulse stat_cap_err, discard the rest of the packet up to and including its tail, then return to IDLE.
- State SEND:
  - out_pgm_alf=1; input beats arriving in SEND or GAP are dropped.
  - Issue a RAM read at address 0..tpl_len-1 each cycle in_pgm_alf=0; hold the address while in_pgm_alf=1.
  - The RAM has 1-cycle read latency; each read produces one out_pgm_data_wr in the next cycle.
  - The tail beat also drives out_pgm_valid_wr=1 and out_pgm_valid=1.
  - After the tail is issued: stat_sent_cnt +1 (saturating).
  - Then go to GAP if cfg_gap≠0, else directly to the next packet or finish.
- State GAP: count cfg_gap cycles, then decide next.
- Next-packet decision: finish if a stop is pending, or if not continuous and stat_sent_cnt == latched count; otherwise SEND from address 0.
- Finish: pulse finish_flag, return to IDLE.
- cfg_stop is sampled in any cycle of SEND/GAP; a packet already started always completes with a tail.
- in_pgm_alf rising in the middle of a packet only pauses it; no beat is lost or duplicated.
- Template length 1: the head beat carries tag 10 as stored; the bytes are replayed unmodified.
- A synchronous reset at any point returns to IDLE; partially sent packets are not completed.

Decomposition:
- Shared package pgm_pkg:
  - Tag constants TAG_HEAD, TAG_MID, TAG_TAIL.
  - State encoding enum IDLE, CAP, SEND, GAP.
  - Default DATA_W.
- Sub-module pgm_tpl_ram: simple dual-port, DEPTH×DATA_W, synchronous write, registered read with 1-cycle latency.
- Top-level FSM, counters and output mux are in pgm_gen.

Test Plan:
- Pass-through: capture_en=0, 3-beat packet in -> same 3 beats out 1 cycle later; valid_wr on the tail; out_pgm_alf follows in_pgm_alf.
- Capture + burst:
  - Capture a 4-beat template -> stat_tpl_len=4, tpl_valid=1, no output.
  - Then start with count=3, gap=5 -> 12 beats out; exactly 5 idle cycles between packets; finish pulse; stat_sent_cnt=3.
- Backpressure: toggle in_pgm_alf every 3 cycles during send -> output beat order identical to the template; no duplicates.
- Continuous + stop: continuous=1, stop asserted during the 2nd beat of packet 7 -> packet 7 completes; finish_flag pulses; stat_sent_cnt=7.
- Overflow: DEPTH=8, 10-beat capture -> stat_cap_err pulse, tpl_valid=0; a following start is ignored with no output.
- Reset mid-send: rst_n low for 1 cycle during SEND -> all outputs 0 next cycle; state IDLE; pass-through resumes.
